// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile
//   Register file (NREGS x DATA_W, r0 hard-wired to zero) plus a three-state
//   issue FSM (IDLE -> EXEC -> WB) that feeds a combinational six_bit_ALU and
//   writes its result back.
//
//   Optional feature macro: ZERO_FLAG_EN (adds output zero_flag).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr_op/rd/rs/rt          ALU opcode, destination, source A, source B
//   instr_use_carry            ADD only: carry_flag is used as carry-in
//   pl_we/pl_addr/pl_data      register preload, honoured only in IDLE
//   alu_a/alu_b/alu_carry_in/alu_op   drive to the ALU (zero outside EXEC)
//   alu_result/alu_carry_out   results from the ALU
//   done/done_rd/done_data     one-cycle retire pulse, rd, written value
//   carry_flag                 sticky carry from the last legal ADD/SUB
//   illegal_op                 pulses with done for an unsupported opcode
//   zero_flag                  (ZERO_FLAG_EN only) result==0 of last legal op
module alu_issue_regfile #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned NREGS  = 8,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs,
    input  logic [AW-1:0]     instr_rt,
    input  logic              instr_use_carry,
    input  logic              pl_we,
    input  logic [AW-1:0]     pl_addr,
    input  logic [DATA_W-1:0] pl_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_carry_in,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry_out,
    output logic              done,
    output logic [AW-1:0]     done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              carry_flag,
`ifdef ZERO_FLAG_EN
    output logic              zero_flag,
`endif
    output logic              illegal_op
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]        op_q;
    logic [AW-1:0]     rd_q;
    logic              uc_q;
    logic [DATA_W-1:0] opa_q, opb_q;

    logic              handshake;
    logic              pl_ok;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              op_legal, op_arith, wb_en;

    assign handshake = instr_valid && instr_ready;

    // r0 is never written, so it always reads back as zero.
    assign pl_ok = pl_we && (state_q == S_IDLE) && (pl_addr != '0);

    // Write-first read: a preload in the handshake cycle is seen by the operand.
    assign rs_val = (pl_ok && (pl_addr == instr_rs)) ? pl_data : regs[instr_rs];
    assign rt_val = (pl_ok && (pl_addr == instr_rt)) ? pl_data : regs[instr_rt];

    assign op_legal = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                      (op_q == OP_SUB) || (op_q == OP_NOR);
    assign op_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign wb_en    = (state_q == S_EXEC) && op_legal && (rd_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_ready  = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;
        alu_carry_in = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a  = opa_q;
                alu_b  = opb_q;
                alu_op = op_q;
                if (op_q == OP_SUB) begin
                    alu_carry_in = 1'b1;
                end else if ((op_q == OP_ADD) && uc_q) begin
                    alu_carry_in = carry_flag;
                end
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            uc_q  <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (handshake) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            uc_q  <= instr_use_carry;
            opa_q <= rs_val;
            opb_q <= rt_val;
        end
    end

    // Register file: preload (IDLE only) and writeback (EXEC only) never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (pl_ok) begin
                regs[pl_addr] <= pl_data;
            end
            if (wb_en) begin
                regs[rd_q] <= alu_result;
            end
        end
    end

    // Retire outputs: captured at the end of EXEC so they are valid in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            illegal_op <= 1'b0;
            done_rd    <= '0;
            done_data  <= '0;
            carry_flag <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_flag  <= 1'b0;
`endif
        end else begin
            done       <= (state_q == S_EXEC);
            illegal_op <= (state_q == S_EXEC) && !op_legal;
            if (state_q == S_EXEC) begin
                done_rd   <= rd_q;
                done_data <= op_legal ? alu_result : '0;
                if (op_legal && op_arith) begin
                    carry_flag <= alu_carry_out;
                end
`ifdef ZERO_FLAG_EN
                if (op_legal) begin
                    zero_flag <= (alu_result == '0);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_regfile.sv
// Directed bench for alu_issue_regfile with a behavioural six_bit_ALU model.
module tb_alu_issue_regfile;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd, instr_rs, instr_rt;
    logic       instr_use_carry;
    logic       pl_we;
    logic [2:0] pl_addr;
    logic [5:0] pl_data;
    logic [5:0] alu_a, alu_b;
    logic       alu_carry_in;
    logic [3:0] alu_op;
    logic [5:0] alu_result;
    logic       alu_carry_out;
    logic       done;
    logic [2:0] done_rd;
    logic [5:0] done_data;
    logic       carry_flag;
    logic       illegal_op;
`ifdef ZERO_FLAG_EN
    logic       zero_flag;
`endif

    int n_checks;
    int n_fail;
    bit pl_during;

    alu_issue_regfile #(.DATA_W(6), .NREGS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_rd       (instr_rd),
        .instr_rs       (instr_rs),
        .instr_rt       (instr_rt),
        .instr_use_carry(instr_use_carry),
        .pl_we          (pl_we),
        .pl_addr        (pl_addr),
        .pl_data        (pl_data),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_carry_in   (alu_carry_in),
        .alu_op         (alu_op),
        .alu_result     (alu_result),
        .alu_carry_out  (alu_carry_out),
        .done           (done),
        .done_rd        (done_rd),
        .done_data      (done_data),
        .carry_flag     (carry_flag),
`ifdef ZERO_FLAG_EN
        .zero_flag      (zero_flag),
`endif
        .illegal_op     (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational six_bit_ALU stand-in
    always_comb begin
        logic [6:0] s;
        s             = '0;
        alu_result    = '0;
        alu_carry_out = 1'b0;
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {6'b0, alu_carry_in};
                {alu_carry_out, alu_result} = s;
            end
            4'b0110: begin
                s = {1'b0, alu_a} + {1'b0, ~alu_b} + {6'b0, alu_carry_in};
                {alu_carry_out, alu_result} = s;
            end
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, check the EXEC drive and the WB retire outputs.
    task automatic run(input string tag, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt, input logic uc,
                       input logic exp_cin, input logic [5:0] exp_data,
                       input logic exp_carry, input logic exp_ill);
        instr_valid     = 1'b1;
        instr_op        = op;
        instr_rd        = rd;
        instr_rs        = rs;
        instr_rt        = rt;
        instr_use_carry = uc;
        tick();
        instr_valid = 1'b0;
        pl_we       = pl_during;
        check({tag, ".exec_ready"}, {7'b0, instr_ready}, 8'h00);
        check({tag, ".exec_done"}, {7'b0, done}, 8'h00);
        check({tag, ".exec_op"}, {4'b0, alu_op}, {4'b0, op});
        check({tag, ".exec_cin"}, {7'b0, alu_carry_in}, {7'b0, exp_cin});
        tick();
        check({tag, ".done"}, {7'b0, done}, 8'h01);
        check({tag, ".done_rd"}, {5'b0, done_rd}, {5'b0, rd});
        check({tag, ".done_data"}, {2'b0, done_data}, {2'b0, exp_data});
        check({tag, ".carry"}, {7'b0, carry_flag}, {7'b0, exp_carry});
        check({tag, ".illegal"}, {7'b0, illegal_op}, {7'b0, exp_ill});
        check({tag, ".wb_alu_a"}, {2'b0, alu_a}, 8'h00);
        tick();
        pl_we = 1'b0;
        check({tag, ".idle_done"}, {7'b0, done}, 8'h00);
        check({tag, ".idle_ready"}, {7'b0, instr_ready}, 8'h01);
    endtask

    task automatic preload(input logic [2:0] addr, input logic [5:0] data);
        pl_we   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        tick();
        pl_we = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        pl_during       = 1'b0;
        rst_n           = 1'b0;
        instr_valid     = 1'b0;
        instr_op        = '0;
        instr_rd        = '0;
        instr_rs        = '0;
        instr_rt        = '0;
        instr_use_carry = 1'b0;
        pl_we           = 1'b0;
        pl_addr         = '0;
        pl_data         = '0;
        tick();
        tick();
        check("rst.done", {7'b0, done}, 8'h00);
        check("rst.carry", {7'b0, carry_flag}, 8'h00);
        check("rst.done_data", {2'b0, done_data}, 8'h00);
        check("rst.alu_op", {4'b0, alu_op}, 8'h00);
        #2 rst_n = 1'b1;
        tick();
        check("rst.ready", {7'b0, instr_ready}, 8'h01);

        // r1 = 100111, r2 = 010101
        preload(3'd1, 6'b100111);
        preload(3'd2, 6'b010101);

        run("and",   4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 6'b000101, 1'b0, 1'b0);
        run("rd_r3", 4'b0001, 3'd5, 3'd3, 3'd0, 1'b0, 1'b0, 6'b000101, 1'b0, 1'b0);
        run("or",    4'b0001, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 6'b110111, 1'b0, 1'b0);
        run("nor",   4'b1100, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 6'b001000, 1'b0, 1'b0);
        run("add",   4'b0010, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 6'b111100, 1'b0, 1'b0);
        run("sub",   4'b0110, 3'd6, 3'd1, 3'd2, 1'b0, 1'b1, 6'b010010, 1'b1, 1'b0);
        run("addc",  4'b0010, 3'd7, 3'd0, 3'd0, 1'b1, 1'b1, 6'b000001, 1'b0, 1'b0);
        run("rd_r7", 4'b0001, 3'd5, 3'd7, 3'd0, 1'b0, 1'b0, 6'b000001, 1'b0, 1'b0);

        // Illegal op with carry_flag set: nothing written, flag kept
        run("sub2",  4'b0110, 3'd6, 3'd1, 3'd2, 1'b0, 1'b1, 6'b010010, 1'b1, 1'b0);
        run("ill",   4'b0011, 3'd6, 3'd2, 3'd2, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b1);
        run("rd_r6", 4'b0001, 3'd5, 3'd6, 3'd0, 1'b0, 1'b0, 6'b010010, 1'b1, 1'b0);

        // r0 stays zero after writeback and preload attempts
        run("wr_r0", 4'b0000, 3'd0, 3'd1, 3'd1, 1'b0, 1'b0, 6'b100111, 1'b1, 1'b0);
        preload(3'd0, 6'b111111);
        run("rd_r0", 4'b0001, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0);

        // Preload in the handshake cycle is seen by the operand read
        pl_we   = 1'b1;
        pl_addr = 3'd1;
        pl_data = 6'b000001;
        run("wfirst", 4'b0001, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 6'b000001, 1'b1, 1'b0);

        // Preload held through EXEC/WB is ignored
        pl_addr   = 3'd2;
        pl_data   = 6'b111111;
        pl_during = 1'b1;
        run("pl_exec", 4'b0000, 3'd5, 3'd1, 3'd1, 1'b0, 1'b0, 6'b000001, 1'b1, 1'b0);
        pl_during = 1'b0;
        run("rd_r2", 4'b0001, 3'd5, 3'd2, 3'd0, 1'b0, 1'b0, 6'b010101, 1'b1, 1'b0);

        // Reset mid-EXEC of ADD into r4
        instr_valid     = 1'b1;
        instr_op        = 4'b0010;
        instr_rd        = 3'd4;
        instr_rs        = 3'd1;
        instr_rt        = 3'd2;
        instr_use_carry = 1'b0;
        tick();
        instr_valid = 1'b0;
        check("mid.exec_op", {4'b0, alu_op}, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check("mid.alu_a", {2'b0, alu_a}, 8'h00);
        check("mid.alu_b", {2'b0, alu_b}, 8'h00);
        check("mid.alu_op", {4'b0, alu_op}, 8'h00);
        check("mid.carry", {7'b0, carry_flag}, 8'h00);
        check("mid.done_data", {2'b0, done_data}, 8'h00);
        check("mid.done_rd", {5'b0, done_rd}, 8'h00);
        tick();
        check("mid.done", {7'b0, done}, 8'h00);
        check("mid.illegal", {7'b0, illegal_op}, 8'h00);
        #2 rst_n = 1'b1;
        tick();
        check("mid.ready", {7'b0, instr_ready}, 8'h01);
        check("mid.done2", {7'b0, done}, 8'h00);
        run("rd_r4", 4'b0001, 3'd5, 3'd4, 3'd0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);
        run("rd_r1", 4'b0001, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_regfile.md
Name: alu_issue_regfile

Overview:
- Upstream/downstream companion to six_bit_ALU: 8-entry x 6-bit register file plus a 3-state issue FSM.
- Accepts one register-to-register instruction per handshake, reads rs/rt, and drives the ALU's a/b/carry_in/ALU_OP.
- Captures ALU result and carry_out and writes the result back to rd.
- Sits between the lab's instruction source (bench or future decoder) and the ALU instance.

Parameters:
DATA_W, 6, operand/register width; must match the ALU width.
NREGS, 8, number of registers; address width is clog2(NREGS) = 3.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  high only in IDLE; transfer occurs when valid&&ready
instr_op  in  4  ALU opcode
instr_rd  in  3  destination register
instr_rs  in  3  source A register
instr_rt  in  3  source B register
instr_use_carry  in  1  ADD only: use carry_flag as carry-in
pl_we  in  1  preload write enable; honoured only in IDLE
pl_addr  in  3  preload address
pl_data  in  6  preload data
alu_a  out  6  to ALU a
alu_b  out  6  to ALU b
alu_carry_in  out  1  to ALU carry_in
alu_op  out  4  to ALU ALU_OP
alu_result  in  6  from ALU result
alu_carry_out  in  1  from ALU carry_out
done  out  1  one-cycle pulse per retired instruction
done_rd  out  3  rd of retired instruction
done_data  out  6  value written, or 0 if illegal
carry_flag  out  1  sticky carry from last legal ADD/SUB
illegal_op  out  1  one-cycle pulse with done for an unsupported opcode

Behaviour:
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR. Any other opcode is illegal.
- Register r0 reads 0. Writes to r0 from writeback or preload are discarded.
- FSM states: IDLE -> EXEC -> WB -> IDLE. The FSM has no other states.
  - IDLE: instr_ready=1. On handshake, latch op/rd/use_carry and operand registers opa=R[rs], opb=R[rt].
    - Read is write-first: a same-cycle pl_we to rs/rt is seen by the read.
    - Next state is EXEC.
  - EXEC (one cycle): alu_a=opa, alu_b=opb, alu_op=op.
    - alu_carry_in = 1 for SUB; carry_flag for ADD with use_carry; otherwise 0.
    - The ALU is combinational. At the end of EXEC, legal ops write alu_result to R[rd] and capture done_data=alu_result.
    - ADD/SUB also update carry_flag=alu_carry_out. AND/OR/NOR leave carry_flag unchanged.
    - Illegal ops write nothing, leave carry_flag unchanged, and set done_data=0.
    - Next state is WB.
  - WB: done=1, done_rd valid, illegal_op=1 if the op was illegal. Next state is IDLE.
- Latency: handshake at cycle N, EXEC at N+1, done at N+2. Throughput is one instruction per 3 cycles.
- Outside EXEC, alu_a/alu_b/alu_op/alu_carry_in are driven 0.
- pl_we outside IDLE is ignored. No error is flagged.
- Back-to-back: the next handshake is possible in the cycle after WB. A later rs read sees the earlier rd write.
- Reset, async at any time including mid-EXEC/WB:
  - FSM returns to IDLE; all registers are 0.
  - carry_flag=0, done=0, illegal_op=0, done_rd=0, done_data=0, ALU drive outputs 0.
  - instr_ready=1 once rst_n is high.
  - The in-flight instruction is dropped with no writeback.

Optional Feature:
ZERO_FLAG_EN
- Defined: adds output zero_flag (1 bit), reset 0. It is updated at the end of EXEC for every legal op to (alu_result==0). Illegal ops leave it unchanged.
- Undefined: the port does not exist, and all other behaviour is identical.

Test Plan:
1. Preload r1=100111, r2=010101; issue AND rd=3 rs=1 rt=2 -> done at N+2, done_data=000101, R3=000101, carry_flag unchanged at 0.
2. Same operands: OR -> 110111; NOR -> 001000; ADD use_carry=0 -> 111100 with carry_flag=0.
3. SUB r1-r2 -> alu_carry_in=1 in EXEC, done_data=010010, carry_flag=1. Then ADD use_carry=1 of r0+r0 -> done_data=000001.
4. instr_op=0011 -> illegal_op and done pulse together, done_data=0, R[rd] and carry_flag unchanged. Write to rd=0 -> r0 still reads 0.
5. pl_we to r1 with value 000001 in the same cycle as a handshake reading rs=1 -> operand uses 000001. pl_we during EXEC -> target register unchanged.
6. Assert rst_n=0 mid-EXEC of ADD into r4 -> all outputs 0 immediately, R4 stays 0, no done pulse, instr_ready=1 after release.
